// File: rtl/fact_mmio_if_if.sv
// rtl/fact_mmio_if_if.sv - CPU word bus and factorial-unit handshake bundle
interface fact_mmio_if_if;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        fact_go;
  logic [3:0]  fact_n;
  logic        fact_done;
  logic        fact_err;
  logic [31:0] fact_prod;
  logic        busy;

  modport master (
    output we, a, wd, fact_done, fact_err, fact_prod,
    input  rd, fact_go, fact_n, busy
  );

  modport slave (
    input  we, a, wd, fact_done, fact_err, fact_prod,
    output rd, fact_go, fact_n, busy
  );
endinterface

// File: rtl/fact_mmio_if.sv
// rtl/fact_mmio_if.sv - memory-mapped launcher, status capture and watchdog for the factorial unit
module fact_mmio_if #(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  fact_mmio_if_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_DONE} state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  n_reg;
  logic        go_reg;
  logic        done_s;
  logic        err_s;
  logic        tout_s;
  logic [31:0] result;
  logic [15:0] wdog;
  logic        done_q;

  logic idle_like;
  logic wr_n;
  logic start;
  logic done_edge;
  logic finish_ok;
  logic finish_to;
  logic unused_wd;

  assign unused_wd = ^bus.wd[31:4];

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign wr_n      = bus.we && (bus.a == 2'd0) && idle_like;
  assign start     = bus.we && (bus.a == 2'd1) && bus.wd[0] && idle_like;
  // Only a rising done counts, so a level left high by the last run cannot complete this one.
  assign done_edge = bus.fact_done & ~done_q;
  assign finish_ok = (state == S_BUSY) && done_edge;
  assign finish_to = (state == S_BUSY) && !done_edge && (wdog == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_LAUNCH;
      S_LAUNCH:       state_nx = S_BUSY;
      S_BUSY:         if (finish_ok || finish_to) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.fact_go = (state == S_LAUNCH);
    bus.busy    = (state == S_LAUNCH) || (state == S_BUSY);
    bus.fact_n  = n_reg;
    bus.rd      = 32'd0;
    case (bus.a)
      2'd0: bus.rd = {28'd0, n_reg};
      2'd1: bus.rd = {31'd0, go_reg};
      2'd2: bus.rd = {29'd0, tout_s, err_s, done_s};
      2'd3: bus.rd = result;
      default: bus.rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      n_reg  <= 4'd0;
      go_reg <= 1'b0;
      done_s <= 1'b0;
      err_s  <= 1'b0;
      tout_s <= 1'b0;
      result <= 32'd0;
      wdog   <= 16'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.fact_done;

      if (wr_n) n_reg <= bus.wd[3:0];

      if (start) begin
        go_reg <= 1'b1;
        done_s <= 1'b0;
        err_s  <= 1'b0;
        tout_s <= 1'b0;
        result <= 32'd0;
      end

      if (state == S_LAUNCH) begin
        wdog <= 16'd0;
      end else if ((state == S_BUSY) && (wdog != 16'hFFFF)) begin
        wdog <= wdog + 16'd1;
      end

      // Normal completion wins over a watchdog expiry on the same cycle.
      if (finish_ok) begin
        done_s <= 1'b1;
        err_s  <= bus.fact_err;
        result <= bus.fact_err ? 32'd0 : bus.fact_prod;
        go_reg <= 1'b0;
      end else if (finish_to) begin
        tout_s <= 1'b1;
        done_s <= 1'b1;
        go_reg <= 1'b0;
        result <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_fact_mmio_if.sv
// tb/tb_fact_mmio_if.sv - scoreboard bench for fact_mmio_if with a behavioural factorial unit
module tb_fact_mmio_if;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fact_mmio_if_if bus();

  fact_mmio_if #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int go_cnt = 0;
  int resp_delay = 0;
  int cnt = 0;
  logic resp_en = 1'b0;
  logic resp_err = 1'b0;
  logic keep_done = 1'b0;
  logic man_mode = 1'b1;
  logic man_done = 1'b0;
  logic [31:0] resp_prod = 32'd0;
  logic [31:0] exp_st_q[$];
  logic [31:0] exp_rs_q[$];

  // Unit model: counts launch pulses and raises done resp_delay cycles after the pulse.
  always @(negedge clk) begin
    if (bus.fact_go === 1'b1) go_cnt++;
    if (man_mode) begin
      bus.fact_done = man_done;
      bus.fact_err  = 1'b0;
      bus.fact_prod = 32'd0;
      cnt = 0;
    end else if (bus.fact_go === 1'b1) begin
      cnt = resp_delay;
      if (!keep_done) bus.fact_done = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && resp_en) begin
        bus.fact_done = 1'b1;
        bus.fact_err  = resp_err;
        bus.fact_prod = resp_prod;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.we = 1'b1; bus.a = addr; bus.wd = data;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_get(input logic [1:0] addr, output logic [31:0] v);
    bus.a = addr;
    #1;
    v = bus.rd;
  endtask

  task automatic launch(input logic [3:0] n, input int d, input logic en, input logic keep,
                        input logic e, input logic [31:0] p,
                        input logic [31:0] est, input logic [31:0] ers);
    resp_delay = d; resp_en = en; keep_done = keep; resp_err = e; resp_prod = p;
    exp_st_q.push_back(est);
    exp_rs_q.push_back(ers);
    wr(2'd0, {28'd0, n});
    wr(2'd1, 32'd1);
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      bc++;
    end
    #1;
  endtask

  task automatic pop_run(output logic [31:0] st, output logic [31:0] rs,
                         output logic [31:0] est, output logic [31:0] ers);
    rd_get(2'd2, st);
    rd_get(2'd3, rs);
    est = exp_st_q.pop_front();
    ers = exp_rs_q.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0; bus.we = 1'b1; bus.a = 2'd1; bus.wd = 32'd1;
    repeat (3) tick();
    vectors++; if (go_cnt !== 0) begin miscompares++; $display("FAIL reset_go: pulses=%0d want 0", go_cnt); end
    bus.we = 1'b0; rst = 1'b1; man_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_get(2'(i), v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_rd%0d: got %0h want 0", i, v); end
    end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.fact_n !== 4'd0) begin miscompares++; $display("FAIL reset_n: got %0d want 0", bus.fact_n); end
    wr(2'd1, 32'd0);
    tick();
    vectors++; if (bus.busy !== 1'b0 || go_cnt !== 0) begin miscompares++; $display("FAIL go_zero: busy=%b pulses=%0d want 0/0", bus.busy, go_cnt); end
    wr(2'd2, 32'd7);
    wr(2'd3, 32'd5);
    rd_get(2'd2, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL status_ro: got %0h want 0", v); end
    rd_get(2'd3, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL result_ro: got %0h want 0", v); end
  endtask

  task automatic test_n5();
    logic [31:0] st, rs, est, ers, v;
    int bc, g0;
    g0 = go_cnt;
    launch(4'd5, 6, 1'b1, 1'b0, 1'b0, 32'd120, 32'd1, 32'd120);
    rd_get(2'd1, v);
    vectors++; if (v !== 32'd1) begin miscompares++; $display("FAIL n5_goreg: got %0h want 1", v); end
    wait_done(bc);
    vectors++; if (bc !== 7) begin miscompares++; $display("FAIL n5_latency: busy cycles=%0d want 7", bc); end
    vectors++; if (go_cnt - g0 !== 1) begin miscompares++; $display("FAIL n5_pulse: go cycles=%0d want 1", go_cnt - g0); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL n5_status: got %0h want %0h", st, est); end
    vectors++; if (rs !== ers) begin miscompares++; $display("FAIL n5_result: got %0d want %0d", rs, ers); end
    rd_get(2'd1, v);
    vectors++; if (v !== 32'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL n5_idle: go=%0h busy=%b want 0/0", v, bus.busy); end
  endtask

  task automatic test_err();
    logic [31:0] st, rs, est, ers;
    int bc;
    launch(4'd13, 3, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'd3, 32'd0);
    wait_done(bc);
    vectors++; if (bc !== 4) begin miscompares++; $display("FAIL err_latency: busy cycles=%0d want 4", bc); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL err_status: got %0h want %0h", st, est); end
    vectors++; if (rs !== ers) begin miscompares++; $display("FAIL err_result: got %0h want %0h", rs, ers); end
  endtask

  task automatic test_busy_writes();
    logic [31:0] st, rs, est, ers, v;
    int bc, g0;
    g0 = go_cnt;
    launch(4'd5, 6, 1'b1, 1'b0, 1'b0, 32'd120, 32'd1, 32'd120);
    wr(2'd0, 32'd7);
    vectors++; if (bus.fact_n !== 4'd5) begin miscompares++; $display("FAIL bw_fact_n: got %0d want 5", bus.fact_n); end
    wr(2'd1, 32'd1);
    wait_done(bc);
    vectors++; if (bc >= 200) begin miscompares++; $display("FAIL bw_hang: busy cycles=%0d want <200", bc); end
    vectors++; if (go_cnt - g0 !== 1) begin miscompares++; $display("FAIL bw_pulse: go cycles=%0d want 1", go_cnt - g0); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL bw_status: got %0h want %0h", st, est); end
    vectors++; if (rs !== ers) begin miscompares++; $display("FAIL bw_result: got %0d want %0d", rs, ers); end
    rd_get(2'd0, v);
    vectors++; if (v !== 32'd5) begin miscompares++; $display("FAIL bw_n: got %0d want 5", v); end
  endtask

  task automatic test_done_on_timeout();
    logic [31:0] st, rs, est, ers;
    int bc;
    launch(4'd9, 8, 1'b1, 1'b0, 1'b0, 32'd362880, 32'd1, 32'd362880);
    wait_done(bc);
    vectors++; if (bc !== 9) begin miscompares++; $display("FAIL tie_latency: busy cycles=%0d want 9", bc); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL tie_status: got %0h want %0h", st, est); end
    vectors++; if (rs !== ers) begin miscompares++; $display("FAIL tie_result: got %0d want %0d", rs, ers); end
  endtask

  task automatic test_timeout();
    logic [31:0] st, rs, est, ers;
    int bc;
    // fact_done is still high from the previous run and never falls.
    launch(4'd4, 3, 1'b0, 1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
    wait_done(bc);
    vectors++; if (bc !== 9) begin miscompares++; $display("FAIL stale_cycles: busy cycles=%0d want 9", bc); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL stale_status: got %0h want %0h", st, est); end
    vectors++; if (rs !== ers) begin miscompares++; $display("FAIL stale_result: got %0h want %0h", rs, ers); end
    launch(4'd4, 3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd0);
    wait_done(bc);
    vectors++; if (bc !== 9) begin miscompares++; $display("FAIL to_cycles: busy cycles=%0d want 9", bc); end
    pop_run(st, rs, est, ers);
    vectors++; if (st !== est) begin miscompares++; $display("FAIL to_status: got %0h want %0h", st, est); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    int g0;
    g0 = go_cnt;
    resp_en = 1'b0; keep_done = 1'b0;
    wr(2'd0, 32'd6);
    wr(2'd1, 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; man_mode = 1'b1; man_done = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      rd_get(2'(i), v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL mid_rd%0d: got %0h want 0", i, v); end
    end
    vectors++; if (bus.busy !== 1'b0 || bus.fact_n !== 4'd0) begin miscompares++; $display("FAIL mid_idle: busy=%b n=%0d want 0/0", bus.busy, bus.fact_n); end
    vectors++; if (go_cnt - g0 !== 1) begin miscompares++; $display("FAIL mid_pulse: go cycles=%0d want 1", go_cnt - g0); end
    man_done = 1'b0;
  endtask

  initial begin
    bus.we = 1'b0; bus.a = 2'd0; bus.wd = 32'd0;
    test_reset();
    test_n5();
    test_err();
    test_busy_writes();
    test_done_on_timeout();
    test_timeout();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
